// File: rtl/encoded_bus_mux.sv
// Encoded bus multiplexer: grants the lowest-index requesting source onto a
// registered bus, reports the encoded index of the granted source, and keeps
// conflict status (live flag, sticky flag, saturating event counter) for
// cycles where more than one source requested the bus.
//
// Every output comes straight from a flop. There is no combinational path
// from any input to any output. The only asynchronous input is clear.
module encoded_bus_mux #(
  parameter int WIDTH     = 32,
  parameter int NUM_SRC   = 24,  // 2..32
  parameter int SEL_W     = 5,   // 2**SEL_W must be >= NUM_SRC
  parameter bit IDLE_ZERO = 1'b1 // 1: bus returns to zero when idle, 0: bus keeps its last value
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic [NUM_SRC*WIDTH-1:0] src_in,
  input  logic [NUM_SRC-1:0]       src_out,
  input  logic                     hold,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         bus_out,
  output logic                     bus_valid,
  output logic [SEL_W-1:0]         sel_code,
  output logic                     conflict,
  output logic                     conflict_sticky,
  output logic [7:0]               conflict_cnt
);

  localparam logic [7:0] CNT_MAX = 8'hFF;

  // Registered state
  logic [WIDTH-1:0] bus_out_q,         bus_out_d;
  logic             bus_valid_q,       bus_valid_d;
  logic [SEL_W-1:0] sel_code_q,        sel_code_d;
  logic             conflict_q,        conflict_d;
  logic             conflict_sticky_q, conflict_sticky_d;
  logic [7:0]       conflict_cnt_q,    conflict_cnt_d;

  // Grant decode results
  logic             grant_any;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             multi_req;

  // Priority encode: the loop runs from the top index down, so the last match
  // it records is the lowest set request bit. Request bits at or above
  // NUM_SRC do not exist, so the index never exceeds NUM_SRC-1.
  always_comb begin
    grant_any  = 1'b0;
    grant_idx  = '0;
    grant_data = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (src_out[k]) begin
        grant_any  = 1'b1;
        grant_idx  = SEL_W'(k);
        grant_data = src_in[k*WIDTH +: WIDTH];
      end
    end
  end

  // Two or more requests: clearing the lowest set bit still leaves a bit set.
  always_comb begin
    multi_req = |(src_out & (src_out - NUM_SRC'(1)));
  end

  // Next state for the bus and the conflict status. Hold freezes everything
  // except the conflict-status clear.
  always_comb begin
    bus_out_d         = bus_out_q;
    bus_valid_d       = bus_valid_q;
    sel_code_d        = sel_code_q;
    conflict_d        = conflict_q;
    conflict_sticky_d = conflict_sticky_q;
    conflict_cnt_d    = conflict_cnt_q;

    if (!hold) begin
      bus_valid_d = grant_any;
      conflict_d  = multi_req;
      if (grant_any) begin
        bus_out_d  = grant_data;
        sel_code_d = grant_idx;
      end else if (IDLE_ZERO) begin
        bus_out_d  = '0;
        sel_code_d = '0;
      end
    end

    // A clear wipes the status. A conflict in the same cycle is then counted
    // on top of the cleared value, so the new event survives the clear.
    if (clr_err) begin
      conflict_sticky_d = 1'b0;
      conflict_cnt_d    = '0;
    end
    if (!hold && multi_req) begin
      conflict_sticky_d = 1'b1;
      if (conflict_cnt_d != CNT_MAX) begin
        conflict_cnt_d = conflict_cnt_d + 8'd1;
      end
    end
  end

  // State registers. An active clear drops any pending sample immediately.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      bus_out_q         <= '0;
      bus_valid_q       <= 1'b0;
      sel_code_q        <= '0;
      conflict_q        <= 1'b0;
      conflict_sticky_q <= 1'b0;
      conflict_cnt_q    <= '0;
    end else begin
      bus_out_q         <= bus_out_d;
      bus_valid_q       <= bus_valid_d;
      sel_code_q        <= sel_code_d;
      conflict_q        <= conflict_d;
      conflict_sticky_q <= conflict_sticky_d;
      conflict_cnt_q    <= conflict_cnt_d;
    end
  end

  assign bus_out         = bus_out_q;
  assign bus_valid       = bus_valid_q;
  assign sel_code        = sel_code_q;
  assign conflict        = conflict_q;
  assign conflict_sticky = conflict_sticky_q;
  assign conflict_cnt    = conflict_cnt_q;

endmodule
